// File: rtl/apb_master_if.sv
// apb_master_if: CPU-side request/response and APB-side bus signals of the bridge
interface apb_master_if;
    logic         transfer;
    logic         write;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         ready;
    logic         err;
    logic [31:0]  PADDR;
    logic         PWRITE;
    logic [31:0]  PWDATA;
    logic         PENABLE;
    logic [3:0]   PSEL;
    logic [127:0] PRDATA;
    logic [3:0]   PREADY;

    modport master (
        input  transfer, write, addr, wdata, PRDATA, PREADY,
        output rdata, ready, err, PADDR, PWRITE, PWDATA, PENABLE, PSEL
    );

    modport slave (
        output transfer, write, addr, wdata, PRDATA, PREADY,
        input  rdata, ready, err, PADDR, PWRITE, PWDATA, PENABLE, PSEL
    );
endinterface

// File: rtl/apb_master.sv
// apb_master: single-outstanding CPU-to-APB bridge with 4-slave decode, timeout and error reporting
module apb_master #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          NUM_SLV     = 4,
    parameter int          TIMEOUT_CYC = 16
) (
    input logic            PCLK,
    input logic            PRESET,
    apb_master_if.master   bus
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, MISS} state_t;

    state_t               state_q, state_d;
    logic [NUM_SLV-1:0]   psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic [31:0]          paddr_q, paddr_d;
    logic                 pwrite_q, pwrite_d;
    logic [31:0]          pwdata_q, pwdata_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 ready_q, ready_d;
    logic                 err_q, err_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 hit;
    logic [1:0]           idx;

    assign hit = bus.addr[31:14] == BASE_ADDR[31:14];
    // The latched address selects which slave's PREADY/PRDATA are looked at
    assign idx = paddr_q[13:12];

    // Next-state and registered-output computation for the SETUP/ACCESS protocol
    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.transfer) begin
                    if (hit) begin
                        paddr_d  = bus.addr;
                        pwrite_d = bus.write;
                        pwdata_d = bus.wdata;
                        psel_d   = NUM_SLV'(1) << bus.addr[13:12];
                        state_d  = SETUP;
                    end else begin
                        state_d = MISS;
                    end
                end
            end
            MISS: begin
                ready_d = 1'b1;
                err_d   = 1'b1;
                state_d = IDLE;
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY[idx]) begin
                    state_d   = IDLE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    ready_d   = 1'b1;
                    rdata_d   = pwrite_q ? rdata_q : bus.PRDATA[{idx, 5'd0} +: 32];
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d   = IDLE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    ready_d   = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any transfer in flight
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            psel_q    <= '0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.PSEL    = psel_q;
    assign bus.PENABLE = penable_q;
    assign bus.PADDR   = paddr_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.rdata   = rdata_q;
    assign bus.ready   = ready_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: table-driven vectors plus scoreboard checks of the APB bridge
module tb_apb_master;
    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    apb_master_if bus ();

    apb_master dut (.PCLK(PCLK), .PRESET(PRESET), .bus(bus));

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  waits;
        logic        hang;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic [3:0]  exp_psel;
        int          exp_selc;
        int          exp_enc;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    int          compared = 0;
    int          mismatched = 0;
    logic [3:0]  waits[4];
    logic [3:0]  hang = 4'b0000;
    logic [31:0] sdata[4];
    int          acc_cnt = 0;
    vec_t        vecs[8];

    assign sdata[0] = 32'h1111_0000;
    assign sdata[1] = 32'h2222_0001;
    assign sdata[2] = 32'hA5A5_0003;
    assign sdata[3] = 32'h4444_0004;
    assign bus.PRDATA = {sdata[3], sdata[2], sdata[1], sdata[0]};

    // Slave model: counts ACCESS cycles; unselected slaves keep PREADY high as noise
    always @(posedge PCLK) acc_cnt <= bus.PENABLE ? acc_cnt + 1 : 0;

    // Selected slave answers after its configured wait states unless hung
    always_comb begin
        for (int i = 0; i < 4; i++)
            bus.PREADY[i] = bus.PSEL[i] ? (!hang[i] && acc_cnt >= int'(waits[i])) : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every ready pulse must match the oldest pending expectation
    always @(negedge PCLK) begin
        if (!PRESET && bus.ready === 1'b1) begin
            if (sbq.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL spurious_ready: got ready=1 expected no pending transfer at %0t", $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_rdata", bus.rdata, e.rdata);
                chk("sb_err", {31'b0, bus.err}, {31'b0, e.err});
            end
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        int lat, selc, enc;
        logic [3:0] seen;
        logic done;
        waits[v.addr[13:12]] = v.waits;
        hang[v.addr[13:12]] = v.hang;
        @(negedge PCLK);
        bus.transfer = 1'b1;
        bus.write = v.wr;
        bus.addr = v.addr;
        bus.wdata = v.wdata;
        sbq.push_back('{v.exp_rdata, v.exp_err});
        @(negedge PCLK);
        bus.transfer = 1'b0;
        lat = 1; selc = 0; enc = 0; seen = '0; done = 1'b0;
        while (!done && lat < 40) begin
            if (bus.PSEL != 4'b0) begin
                selc++;
                seen |= bus.PSEL;
                if (selc == 1) begin
                    chk({tag, "_paddr"}, bus.PADDR, v.addr);
                    chk({tag, "_pwdata"}, bus.PWDATA, v.wdata);
                    chk({tag, "_pwrite"}, {31'b0, bus.PWRITE}, {31'b0, v.wr});
                end
            end
            if (bus.PENABLE) enc++;
            if (bus.ready) done = 1'b1;
            else begin
                @(negedge PCLK);
                lat++;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, "_psel_seen"}, {28'b0, seen}, {28'b0, v.exp_psel});
        chk({tag, "_psel_cycles"}, 32'(selc), 32'(v.exp_selc));
        chk({tag, "_penable_cycles"}, 32'(enc), 32'(v.exp_enc));
        chk({tag, "_idle_bus"}, {27'b0, bus.PSEL, bus.PENABLE}, 32'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        logic [31:0] acc_val;
        vecs[0] = '{1'b1, 32'h1000_1004, 32'h0000_000F, 4'd0, 1'b0, 1'b0, 32'h0000_0000, 3, 4'b0010, 2, 1};
        vecs[1] = '{1'b0, 32'h1000_2000, 32'h0, 4'd3, 1'b0, 1'b0, 32'hA5A5_0003, 6, 4'b0100, 5, 4};
        vecs[2] = '{1'b0, 32'h2000_0000, 32'h0, 4'd0, 1'b0, 1'b1, 32'hA5A5_0003, 2, 4'b0000, 0, 0};
        vecs[3] = '{1'b0, 32'h1000_3000, 32'h0, 4'd0, 1'b1, 1'b1, 32'hA5A5_0003, 18, 4'b1000, 17, 16};
        vecs[4] = '{1'b0, 32'h1000_0FFC, 32'h0, 4'd1, 1'b0, 1'b0, 32'h1111_0000, 4, 4'b0001, 3, 2};
        vecs[5] = '{1'b0, 32'h1000_4000, 32'h0, 4'd0, 1'b0, 1'b1, 32'h1111_0000, 2, 4'b0000, 0, 0};
        vecs[6] = '{1'b1, 32'h0FFF_F000, 32'h0000_1234, 4'd0, 1'b0, 1'b1, 32'h1111_0000, 2, 4'b0000, 0, 0};
        vecs[7] = '{1'b1, 32'h1000_3008, 32'hCAFE_BABE, 4'd0, 1'b0, 1'b0, 32'h1111_0000, 3, 4'b1000, 2, 1};
        for (int i = 0; i < 4; i++) waits[i] = 4'd0;
        bus.transfer = 1'b0;
        bus.write = 1'b0;
        bus.addr = 32'h0;
        bus.wdata = 32'h0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_flags", {29'b0, bus.ready, bus.err, bus.PENABLE}, 32'h0);
        chk("rst_paddr", bus.PADDR, 32'h0);
        chk("rst_pwdata", bus.PWDATA, 32'h0);
        chk("rst_psel_pwrite", {27'b0, bus.PSEL, bus.PWRITE}, 32'h0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back writes with transfer held high and mid-transfer request changes
        waits[1] = 4'd0;
        hang[1] = 1'b0;
        acc_val = 32'h0;
        @(negedge PCLK);
        for (int k = 0; k < 13; k++) begin
            if (k > 0) chk("b2b_ready", {31'b0, bus.ready}, {31'b0, k % 3 == 0});
            if (k % 3 != 0) chk("b2b_pwdata", bus.PWDATA, acc_val);
            if (k == 12) bus.transfer = 1'b0;
            else begin
                if (k % 3 == 0) begin
                    acc_val = ((k / 3) % 2 != 0) ? 32'h0 : 32'hF;
                    bus.wdata = acc_val;
                    sbq.push_back('{32'h1111_0000, 1'b0});
                end else bus.wdata = 32'hDEAD_0000 | 32'(k);
                bus.transfer = 1'b1;
                bus.write = 1'b1;
                bus.addr = 32'h1000_1004;
            end
            @(negedge PCLK);
        end

        // Reset during ACCESS of a stalled transfer
        hang[3] = 1'b1;
        bus.transfer = 1'b1;
        bus.write = 1'b0;
        bus.addr = 32'h1000_3000;
        @(negedge PCLK);
        bus.transfer = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("mid_penable", {31'b0, bus.PENABLE}, 32'h1);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        chk("mid_rst_bus", {27'b0, bus.PSEL, bus.PENABLE}, 32'h0);
        chk("mid_rst_paddr", bus.PADDR, 32'h0);
        chk("mid_rst_rdata", bus.rdata, 32'h0);
        for (int k = 0; k < 20; k++) begin
            chk("mid_rst_no_ready", {31'b0, bus.ready}, 32'h0);
            @(negedge PCLK);
        end
        run_vec('{1'b1, 32'h1000_1004, 32'h0000_0055, 4'd0, 1'b0, 1'b0, 32'h0, 3, 4'b0010, 2, 1}, "post_rst");

        @(negedge PCLK);
        chk("sb_drained", 32'(sbq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
APB bridge between the RISC-V core's data-memory bus and the peripheral APB segment. It is the upstream stage that drives the GPO/GPI/peripheral slaves.
- Accepts one CPU transfer request at a time.
- Decodes the address to one of 4 slaves and runs the APB SETUP/ACCESS protocol.
- Returns read data plus a one-cycle ready pulse to the core, with error reporting for unmapped addresses and hung slaves.

Parameters:
- BASE_ADDR, 32'h1000_0000, start of the peripheral window; slave i occupies BASE_ADDR + i*32'h1000 (4 KB each).
- NUM_SLV, 4, number of slave select lines (fixed at 4 for this revision).
- TIMEOUT_CYC, 16, max ACCESS cycles waited for PREADY before aborting with error.

Ports:
- PCLK  input  1  system clock; all logic on rising edge.
- PRESET  input  1  synchronous, active-high reset.
- transfer  input  1  CPU request strobe; sampled only in IDLE.
- write  input  1  1 = write, 0 = read; sampled with transfer.
- addr  input  32  CPU byte address; sampled with transfer.
- wdata  input  32  CPU write data; sampled with transfer.
- rdata  output  32  read data returned to the CPU.
- ready  output  1  one-cycle completion pulse.
- err  output  1  qualifies ready; 1 = unmapped address or timeout.
- PADDR  output  32  APB address (latched CPU addr).
- PWRITE  output  1  APB direction.
- PWDATA  output  32  APB write data.
- PENABLE  output  1  APB access phase.
- PSEL  output  4  one-hot slave select; bit i = slave i.
- PRDATA  input  128  slave read data, slave i on bits [32i+31:32i].
- PREADY  input  4  slave ready, bit i = slave i.

Behaviour:
- **Reset** (PRESET high at a PCLK edge): state IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rdata=0, ready=0, err=0, timeout counter=0.
- **Mid-operation reset:** PRESET in SETUP or ACCESS aborts the transfer. PSEL/PENABLE are 0 after that edge, and no ready pulse is ever issued for the aborted transfer.
- **Address decode:** hit when addr[31:14] == BASE_ADDR[31:14]; slave index = addr[13:12].
- **FSM** (all outputs registered):
  - IDLE: PSEL=0, PENABLE=0, ready=0.
    - transfer=1 and hit at edge N: latch addr/write/wdata into PADDR/PWRITE/PWDATA, set PSEL[idx]=1, go to SETUP.
    - transfer=1 and miss at edge N: after edge N+1, ready=1, err=1, rdata unchanged, no APB activity; then back to IDLE.
  - SETUP (exactly 1 cycle): PSEL held, PENABLE=0; next edge → ACCESS with PENABLE=1, counter cleared.
  - ACCESS: PSEL, PENABLE, PADDR, PWRITE, PWDATA held stable.
    - If PREADY[idx]=1 at an edge: go to IDLE, drop PSEL/PENABLE, pulse ready=1, err=0 for one cycle. For reads, rdata ← PRDATA[idx slice] at that edge; for writes, rdata holds its previous value.
    - Else the counter increments. When TIMEOUT_CYC consecutive ACCESS edges see no PREADY: go to IDLE, drop PSEL/PENABLE, pulse ready=1, err=1; rdata is unchanged.
- **Latency:** transfer sampled at edge N, slave with zero wait states:
  - PSEL high after N.
  - PENABLE high after N+1.
  - PREADY sampled at N+2.
  - ready/rdata valid during the cycle after N+2.
  - Each wait state adds 1 cycle.
- **Busy / back-to-back:**
  - transfer while not in IDLE is ignored and never queued.
  - The earliest next transfer is accepted at the edge on which ready is high (state already IDLE).
- **Slave isolation:**
  - PREADY/PRDATA of non-selected slaves are ignored.
  - PSEL is never multi-hot.
- **Stability:** PADDR/PWDATA/PWRITE keep their last values in IDLE; they change only when a new mapped transfer is accepted.

Test Plan:
1. **Write, zero wait:** write 32'h0000_000F to 32'h1000_1004 with slave 1 PREADY tied high → PSEL=4'b0010 for 2 cycles, PENABLE high 1 cycle, PADDR=32'h1000_1004, PWDATA=32'hF; ready=1, err=0 one cycle after the ACCESS edge.
2. **Read, 3 wait states:** read 32'h1000_2000, slave 2 returns PRDATA[95:64]=32'hA5A5_0003 with PREADY high on the 4th ACCESS cycle → PENABLE high 4 cycles; rdata=32'hA5A5_0003 with ready=1, err=0; total latency 6 edges from transfer.
3. **Unmapped:** read 32'h2000_0000 → PSEL stays 0, ready=1, err=1 one cycle later, rdata keeps its prior value 32'hA5A5_0003.
4. **Timeout:** read 32'h1000_3000 with PREADY[3] held 0 → after 16 ACCESS cycles PSEL/PENABLE drop, ready=1, err=1, rdata unchanged.
5. **Busy and back-to-back:**
   - Hold transfer high continuously with alternating writes 4'hF / 4'h0 to 32'h1000_1004 → one APB transfer per 3 edges, ready pulses every 3rd cycle.
   - A request changed mid-transfer has no effect on PADDR/PWDATA.
6. **Reset mid-access:** assert PRESET for 1 cycle during ACCESS of a stalled transfer → PSEL=0, PENABLE=0, ready stays 0, all outputs at reset values; a following write completes normally.
